// File: rtl/mux_arbiter.sv
// -----------------------------------------------------------------------------
// mux_arbiter
//
// Round-robin arbiter in front of a shared 4:1 serial line. One of four
// requesters owns the line for at most BURST_LEN consecutive cycles. The
// owner's data bit x[sel] is registered onto y with a one-cycle latency.
//
// Parameters
//   BURST_LEN  maximum consecutive cycles of ownership (1..16)
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   req    in   [3:0] request vector, req[i] = requester i wants the line
//   x      in   [3:0] per-requester serial data bits
//   sel    out  [1:0] index of the current owner / line-mux select
//   gnt    out  [3:0] one-hot grant, zero when there is no owner
//   y      out  registered shared-line data
//   valid  out  y carries owner data
// -----------------------------------------------------------------------------
module mux_arbiter #(
   parameter int BURST_LEN = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic [3:0] x,
   output logic [1:0] sel,
   output logic [3:0] gnt,
   output logic       y,
   output logic       valid
);

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   // Counter holds the remaining cycles of the burst after the current one.
   localparam logic [3:0] CNT_LOAD = 4'(BURST_LEN - 1);

   state_t     state_q, state_d;
   logic [1:0] ptr_q,   ptr_d;
   logic [3:0] cnt_q,   cnt_d;
   logic [1:0] sel_q,   sel_d;
   logic       y_q,     y_d;
   logic       valid_q, valid_d;

   logic [2:0] pick_idle;   // {found, index} when arbitrating from IDLE
   logic [2:0] pick_hand;   // {found, index} when handing off at grant end
   logic [1:0] ptr_next;
   logic [3:0] owner_mask;
   logic       grant_end;

   // Round-robin search: first set bit of r starting at position p, wrapping.
   // Iterating from the farthest offset down lets the nearest hit win.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         idx = p + 2'(k);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         cnt_q   <= 4'd0;
         sel_q   <= 2'd0;
         y_q     <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         y_q     <= y_d;
         valid_q <= valid_d;
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves a
      // variable unassigned, which would otherwise infer a latch.
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      y_d     = 1'b0;
      valid_d = 1'b0;

      ptr_next   = sel_q + 2'd1;
      owner_mask = 4'b0001 << sel_q;
      grant_end  = (cnt_q == 4'd0) || !req[sel_q];
      pick_idle  = rr_pick(req, ptr_q);
      // Hand-off ignores the outgoing owner; it only gets the line back below
      // when nobody else is asking.
      pick_hand  = rr_pick(req & ~owner_mask, ptr_next);

      unique case (state_q)
         IDLE: begin
            if (pick_idle[2]) begin
               state_d = OWN;
               sel_d   = pick_idle[1:0];
               cnt_d   = CNT_LOAD;
            end
         end
         OWN: begin
            // The releasing cycle still carries the owner's data.
            y_d     = x[sel_q];
            valid_d = 1'b1;
            if (grant_end) begin
               ptr_d = ptr_next;
               if (pick_hand[2]) begin
                  sel_d = pick_hand[1:0];
                  cnt_d = CNT_LOAD;
               end else if (req[sel_q]) begin
                  cnt_d = CNT_LOAD;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs: grant is a pure decode of the registered owner.
   always_comb begin
      gnt   = (state_q == OWN) ? (4'b0001 << sel_q) : 4'b0000;
      sel   = sel_q;
      y     = y_q;
      valid = valid_q;
   end

endmodule

// File: tb/tb_mux_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_arbiter
//
// Drives two arbiters (BURST_LEN=4 and BURST_LEN=1) with identical stimulus.
// A behavioural model per instance predicts the gnt/valid/y seen after each
// edge and queues it; a monitor pops and compares one entry per edge.
// -----------------------------------------------------------------------------
module tb_mux_arbiter;

   typedef struct packed {
      logic [3:0] gnt;
      logic       valid;
      logic       y;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b0000;
   logic [3:0] x = 4'b0000;

   logic [1:0] sel_a, sel_b;
   logic [3:0] gnt_a, gnt_b;
   logic       y_a, y_b, valid_a, valid_b;

   int checks = 0;
   int errors = 0;

   exp_t q_a[$];
   exp_t q_b[$];

   // Model state: owner (-1 = none), cycles used in the current burst, pointer.
   int m_owner[2];
   int m_used[2];
   int m_ptr[2];
   int m_blen[2];

   always #5 clk = ~clk;

   mux_arbiter #(.BURST_LEN(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .req(req), .x(x),
      .sel(sel_a), .gnt(gnt_a), .y(y_a), .valid(valid_a)
   );

   mux_arbiter #(.BURST_LEN(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .req(req), .x(x),
      .sel(sel_b), .gnt(gnt_b), .y(y_b), .valid(valid_b)
   );

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_owner[d] = -1;
         m_used[d]  = 0;
         m_ptr[d]   = 0;
      end
   endtask

   // First requester at or after ptr (mod 4), skipping 'skip'; -1 if none.
   function automatic int find_req(input logic [3:0] r, input int ptr, input int skip);
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (ptr + k) % 4;
         if (r[i] && i != skip) return i;
      end
      return -1;
   endfunction

   // Advance one model by one rising edge with inputs r/xv; queue the outputs.
   task automatic model_step(input int d, input logic [3:0] r, input logic [3:0] xv);
      exp_t e;
      int   w;
      e.valid = (m_owner[d] >= 0);
      e.y     = (m_owner[d] >= 0) ? xv[m_owner[d]] : 1'b0;
      if (m_owner[d] < 0) begin
         w = find_req(r, m_ptr[d], -1);
         if (w >= 0) begin
            m_owner[d] = w;
            m_used[d]  = 1;
         end
      end else if (m_used[d] >= m_blen[d] || !r[m_owner[d]]) begin
         m_ptr[d] = (m_owner[d] + 1) % 4;
         w = find_req(r, m_ptr[d], m_owner[d]);
         if (w >= 0) begin
            m_owner[d] = w;
            m_used[d]  = 1;
         end else if (r[m_owner[d]]) begin
            m_used[d] = 1;
         end else begin
            m_owner[d] = -1;
         end
      end else begin
         m_used[d]++;
      end
      e.gnt = 4'b0000;
      if (m_owner[d] >= 0) e.gnt[m_owner[d]] = 1'b1;
      if (d == 0) q_a.push_back(e);
      else        q_b.push_back(e);
   endtask

   // Apply inputs for the next rising edge and record the expectation.
   task automatic step(input logic [3:0] r, input logic [3:0] xv);
      @(negedge clk);
      req = r;
      x   = xv;
      model_step(0, r, xv);
      model_step(1, r, xv);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_gnt_a"},   gnt_a,         4'b0000);
      check({tag, "_vy_a"},    {2'b00, valid_a, y_a}, 4'b0000);
      check({tag, "_sel_a"},   {2'b00, sel_a}, 4'b0000);
      check({tag, "_gnt_b"},   gnt_b,         4'b0000);
      check({tag, "_vy_b"},    {2'b00, valid_b, y_b}, 4'b0000);
   endtask

   // Reset asserted between edges; outputs must clear without a clock edge.
   task automatic pulse_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("async_rst");
      model_reset();
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   // Monitor: one comparison set per edge while out of reset.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst_n) begin
         if (q_a.size() == 0 || q_b.size() == 0) begin
            check("sb_underflow", 4'd1, 4'd0);
         end else begin
            e = q_a.pop_front();
            check("gnt_a",   gnt_a, e.gnt);
            check("valid_a", {3'b000, valid_a}, {3'b000, e.valid});
            check("y_a",     {3'b000, y_a}, {3'b000, e.y});
            e = q_b.pop_front();
            check("gnt_b",   gnt_b, e.gnt);
            check("valid_b", {3'b000, valid_b}, {3'b000, e.valid});
            check("y_b",     {3'b000, y_b}, {3'b000, e.y});
         end
         check("onehot_a", {3'b000, $onehot0(gnt_a)}, 4'b0001);
         check("onehot_b", {3'b000, $onehot0(gnt_b)}, 4'b0001);
      end
   end

   initial begin
      logic [3:0] r;
      m_blen[0] = 4;
      m_blen[1] = 1;
      model_reset();

      // Power-on reset.
      #2;
      check_outputs_zero("por");
      @(posedge clk);
      #3;
      rst_n = 1'b1;

      // Single requester 2 held: burst of 4 then back-to-back regrant.
      repeat (3) step(4'b0000, 4'b0100);
      repeat (10) step(4'b0100, 4'b0100);

      // Requester 0 alone, then everyone drops: return to IDLE.
      repeat (3) step(4'b0001, 4'($urandom_range(0, 15)));
      repeat (4) step(4'b0000, 4'($urandom_range(0, 15)));

      // All four continuously from ptr=0: rotation 0,1,2,3.
      pulse_reset();
      repeat (18) step(4'b1111, 4'($urandom_range(0, 15)));

      // Reset mid-OWN, then 1 and 3 request; 1 drops after two cycles.
      pulse_reset();
      repeat (2) step(4'b1010, 4'($urandom_range(0, 15)));
      repeat (5) step(4'b1000, 4'($urandom_range(0, 15)));
      repeat (2) step(4'b0000, 4'($urandom_range(0, 15)));

      // Requesters 0 and 2 alternating.
      pulse_reset();
      repeat (10) step(4'b0101, 4'($urandom_range(0, 15)));

      // Random traffic; requests tend to persist so bursts run to completion.
      r = 4'b0000;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
         step(r, 4'($urandom_range(0, 15)));
      end
      step(4'b0000, 4'b0000);

      @(posedge clk);
      #2;
      check("sb_drain", 4'(q_a.size() + q_b.size()), 4'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4, giving the maximum consecutive cycles one requester may own the shared line (legal range 1..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req, input, 4 bits: req[i] high means requester i wants the line.
REQ-005 SHALL have port x, input, 4 bits: x[i] is requester i's serial data bit.
REQ-006 SHALL have port sel, output, 2 bits: index of the current owner, and the select for the shared 4:1 line mux.
REQ-007 SHALL have port gnt, output, 4 bits: one-hot grant, all zero when there is no owner.
REQ-008 SHALL have port y, output, 1 bit: registered shared-line data.
REQ-009 SHALL have port valid, output, 1 bit: y carries owner data.

Function
REQ-010 SHALL implement two states: IDLE (no owner) and OWN (gnt one-hot).
REQ-011 SHALL keep a 2-bit round-robin pointer ptr; arbitration picks the first i with req[i]=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-012 In IDLE with req!=0, SHALL pick the winner, and on the next edge: enter OWN, set sel=winner, set gnt=1<<winner, and load the burst counter cnt=BURST_LEN-1.
REQ-013 In IDLE with req==0, SHALL hold sel, keep gnt=0 and valid=0, and leave ptr unchanged.
REQ-014 In OWN, each edge SHALL register y<=x[sel] and valid<=1, so data has one-cycle latency from x to y.
REQ-015 In OWN, the grant SHALL end when cnt==0, or when req[sel]==0 is sampled at an edge; otherwise cnt decrements.
REQ-016 On grant end, SHALL set ptr=sel+1 (mod 4).
REQ-017 On grant end, SHALL arbitrate the same cycle using the updated ptr, ignoring the current owner's request.
REQ-018 On grant end with a winner, SHALL grant it on the next edge with no idle gap, reloading cnt.
REQ-019 On grant end with no other requester, SHALL return to IDLE.
REQ-020 On grant end with no other requester but req[sel] still high, SHALL regrant the same requester (back-to-back, with a fresh cnt).
REQ-021 When a requester drops req while owning the line, the cycle that samples req[sel]==0 SHALL still produce y/valid for that cycle's x; gnt clears on the following edge.
REQ-022 In IDLE, and on the edge after OWN exits to IDLE, SHALL drive valid=0 and y=0.
REQ-023 gnt SHALL always equal (state==OWN) ? 1<<sel : 0, and SHALL never have more than one bit set.
REQ-024 With all four requesting continuously, each requester SHALL own the line for exactly BURST_LEN cycles in the order 0,1,2,3,0,…
REQ-025 With BURST_LEN=1, the grant SHALL rotate every cycle.
REQ-026 Request changes from non-owners during OWN SHALL NOT affect the current grant.

Reset
REQ-027 rst_n low SHALL immediately, independent of clk, force state=IDLE, ptr=0, cnt=0, sel=0, gnt=0, y=0, and valid=0.
REQ-028 A reset asserted during OWN SHALL abort the grant with no further valid cycles.
REQ-029 After rst_n rises, the first arbitration SHALL occur at the first rising edge with req!=0.

Verification
REQ-030 Bench SHALL cover: after reset, req=4'b0100 and x=4'b0100 held -> next edge sel=2, gnt=4'b0100; one edge later y=1, valid=1; grant lasts 4 cycles, then is regranted to 2 with no gap.
REQ-031 Bench SHALL cover: req=4'b1111 for 16 cycles, BURST_LEN=4 -> gnt sequence 0001×4, 0010×4, 0100×4, 1000×4.
REQ-032 Bench SHALL cover: owner 1 drops req after 2 cycles while req[3]=1 -> gnt goes 0010 to 1000 on the following edge, ptr=2, no idle cycle.
REQ-033 Bench SHALL cover: owner 0 and req goes to 0 -> return to IDLE, valid=0 one edge after the release; gnt=0.
REQ-034 Bench SHALL cover: rst_n pulsed low mid-OWN between clock edges -> gnt=0, valid=0, y=0 immediately; after release with req=4'b1010 -> grant goes to 1 (ptr=0).
REQ-035 Bench SHALL cover: BURST_LEN=1 with req=4'b0101 -> gnt alternates 0001, 0100 every cycle; y tracks x[0] and x[2] delayed by one cycle.
